render_target_buffer: RTL and testbench

Synthesisable, parametrised colour-plus-depth render target. It replaces the behavioural frame/Z arrays used in simulation and sits between the rasterizer (Z read, pixel/Z write) and display scan-out. It adds a hardware fast-clear engine, same-cycle read-after-write bypass, out-of-range protection and an independent scan-out read port.

---
 rtl/render_target_buffer.sv | 151 +++++++++++++++
 tb/tb_render_target_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/render_target_buffer.sv
// render_target_buffer: colour + depth render target with fast-clear sweep,
// Z read-after-write bypass, range protection and a scan-out read port.
module render_target_buffer #(
   parameter int               H_RES          = 320,
   parameter int               V_RES          = 240,
   parameter int               ADDR_W         = 17,
   parameter int               PIX_W          = 12,
   parameter int               Z_W            = 8,
   parameter logic [PIX_W-1:0] CLEAR_COLOR    = '0,
   parameter logic [Z_W-1:0]   CLEAR_Z        = '1,
   parameter bit               CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] i_zr_addr,
   output logic [Z_W-1:0]    o_zr_data,
   input  logic [ADDR_W-1:0] i_w_addr,
   input  logic              i_fb_we,
   input  logic [PIX_W-1:0]  i_fb_pixel,
   input  logic              i_zb_we,
   input  logic [Z_W-1:0]    i_zb_data,
   input  logic [ADDR_W-1:0] i_sr_addr,
   output logic [PIX_W-1:0]  o_sr_pixel,
   input  logic              i_clear,
   output logic              o_busy,
   output logic              o_clear_done,
   output logic              o_oob
);

   localparam int N = H_RES * V_RES;
   localparam logic [ADDR_W:0]   N_EXT = (ADDR_W + 1)'(N);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N - 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_CLEAR = 1'b1;

   logic [PIX_W-1:0] mem_fb [N];
   logic [Z_W-1:0]   mem_z  [N];

   logic [0:0]        state;
   logic [ADDR_W-1:0] cnt;
   logic              idle;
   logic              w_in;
   logic              zr_in;
   logic              sr_in;
   logic              fb_acc;
   logic              zb_acc;

   logic [ADDR_W-1:0] mw_addr;
   logic              mw_fb;
   logic              mw_z;
   logic [PIX_W-1:0]  mw_pix;
   logic [Z_W-1:0]    mw_zd;

   logic [Z_W-1:0]    zr_q;
   logic [PIX_W-1:0]  sr_q;
   logic              zr_force;
   logic              zr_byp;
   logic [Z_W-1:0]    zr_byp_d;
   logic              sr_force;

   assign idle   = (state == S_IDLE);
   assign w_in   = {1'b0, i_w_addr} < N_EXT;
   assign zr_in  = {1'b0, i_zr_addr} < N_EXT;
   assign sr_in  = {1'b0, i_sr_addr} < N_EXT;
   assign fb_acc = idle & i_fb_we & w_in;
   assign zb_acc = idle & i_zb_we & w_in;

   // Single write port: the clear sweep owns it while busy.
   always_comb begin
      mw_addr = i_w_addr;
      mw_fb   = fb_acc;
      mw_z    = zb_acc;
      mw_pix  = i_fb_pixel;
      mw_zd   = i_zb_data;
      if (!idle) begin
         mw_addr = cnt;
         mw_fb   = 1'b1;
         mw_z    = 1'b1;
         mw_pix  = CLEAR_COLOR;
         mw_zd   = CLEAR_Z;
      end
   end

   // Clear FSM, sweep counter, done pulse and sticky range flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
         cnt          <= '0;
         o_clear_done <= 1'b0;
         o_oob        <= 1'b0;
      end else begin
         o_clear_done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if ((i_fb_we | i_zb_we) & !w_in)
                  o_oob <= 1'b1;
               if (i_clear) begin
                  state <= S_CLEAR;
                  cnt   <= '0;
                  o_oob <= 1'b0;
               end
            end
            S_CLEAR: begin
               if (cnt == LAST) begin
                  state        <= S_IDLE;
                  cnt          <= '0;
                  o_clear_done <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // Array write port.
   always_ff @(posedge clk) begin
      if (mw_fb)
         mem_fb[mw_addr] <= mw_pix;
      if (mw_z)
         mem_z[mw_addr] <= mw_zd;
   end

   // Two synchronous read ports, read-first.
   always_ff @(posedge clk) begin
      zr_q <= mem_z[i_zr_addr];
      sr_q <= mem_fb[i_sr_addr];
   end

   // Output select kept outside the RAM so the arrays map to block RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zr_force <= 1'b1;
         zr_byp   <= 1'b0;
         zr_byp_d <= CLEAR_Z;
         sr_force <= 1'b1;
      end else begin
         zr_force <= !idle | !zr_in;
         zr_byp   <= zb_acc & (i_w_addr == i_zr_addr);
         zr_byp_d <= i_zb_data;
         sr_force <= !sr_in;
      end
   end

   assign o_zr_data  = zr_force ? CLEAR_Z :
                       zr_byp   ? zr_byp_d : zr_q;
   assign o_sr_pixel = sr_force ? CLEAR_COLOR : sr_q;
   assign o_busy     = (state == S_CLEAR);

endmodule

// File: tb/tb_render_target_buffer.sv
// tb_render_target_buffer: directed stimulus, cycle model and literal checks
// for the render target; a second instance covers CLEAR_ON_RESET = 0.
module tb_render_target_buffer;

   localparam int N  = 40 * 30;
   localparam int AW = 11;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] zr_addr = '0;
   logic [AW-1:0] w_addr = '0;
   logic [AW-1:0] sr_addr = '0;
   logic          fb_we = 1'b0;
   logic          zb_we = 1'b0;
   logic [11:0]   pix = '0;
   logic [7:0]    zd = '0;
   logic          clr = 1'b0;

   logic [7:0]    zr_data, zr0;
   logic [11:0]   sr_pixel, sr0;
   logic          busy, done, oob;
   logic          busy0, done0, oob0;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   render_target_buffer #(
      .H_RES(40), .V_RES(30), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_zr_addr(zr_addr), .o_zr_data(zr_data),
      .i_w_addr(w_addr), .i_fb_we(fb_we), .i_fb_pixel(pix),
      .i_zb_we(zb_we), .i_zb_data(zd),
      .i_sr_addr(sr_addr), .o_sr_pixel(sr_pixel),
      .i_clear(clr), .o_busy(busy),
      .o_clear_done(done), .o_oob(oob)
   );

   render_target_buffer #(
      .H_RES(40), .V_RES(30), .ADDR_W(AW), .CLEAR_ON_RESET(1'b0)
   ) dut0 (
      .clk(clk), .rst_n(rst_n),
      .i_zr_addr(zr_addr), .o_zr_data(zr0),
      .i_w_addr(w_addr), .i_fb_we(fb_we), .i_fb_pixel(pix),
      .i_zb_we(zb_we), .i_zb_data(zd),
      .i_sr_addr(sr_addr), .o_sr_pixel(sr0),
      .i_clear(clr), .o_busy(busy0),
      .o_clear_done(done0), .o_oob(oob0)
   );

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t",
                  nm, got, exp, $time);
      end
   endtask

   // Model of dut: frame contents, remaining sweep length, flags.
   logic [11:0] mfb [N];
   logic [7:0]  mz  [N];
   bit          mv  [N];
   logic [7:0]  m_zr;
   logic [11:0] m_sr;
   bit          m_srv, m_done, m_oob;
   int          m_left, m_idx, wa, za, sa;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_zr = 8'hFF; m_sr = '0; m_srv = 1;
         m_done = 0; m_oob = 0;
         m_left = N; m_idx = 0;
      end else begin
         wa = int'(w_addr); za = int'(zr_addr); sa = int'(sr_addr);
         if (sa >= N) begin
            m_sr = '0; m_srv = 1;
         end else begin
            m_sr = mfb[sa]; m_srv = mv[sa];
         end
         if (m_left > 0 || za >= N) m_zr = 8'hFF;
         else if (zb_we && wa == za) m_zr = zd;
         else m_zr = mz[za];
         m_done = 0;
         if (m_left > 0) begin
            mfb[m_idx] = '0; mz[m_idx] = 8'hFF; mv[m_idx] = 1;
            m_idx++; m_left--;
            if (m_left == 0) m_done = 1;
         end else begin
            if (wa < N) begin
               if (fb_we) begin mfb[wa] = pix; mv[wa] = 1; end
               if (zb_we) mz[wa] = zd;
            end else if (fb_we || zb_we) begin
               m_oob = 1;
            end
            if (clr) begin m_left = N; m_idx = 0; m_oob = 0; end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("oob", 32'(oob), 32'(m_oob));
      chk("zr", 32'(zr_data), 32'(m_zr));
      if (m_srv) chk("sr", 32'(sr_pixel), 32'(m_sr));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(output int c);
      c = 0;
      while (busy && c < 4 * N) begin
         step();
         c++;
      end
   endtask

   initial begin
      #(200_000 * 10);
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c;
      int rd [3];
      rd[0] = 0; rd[1] = 160; rd[2] = N - 1;
      repeat (2) step();
      chk("rst_busy", 32'(busy), 1);
      chk("rst_busy0", 32'(busy0), 0);
      chk("rst_zr", 32'(zr_data), 32'h0FF);
      chk("rst_sr", 32'(sr_pixel), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_oob", 32'(oob), 0);

      rst_n = 1'b1;
      wait_idle(c);
      chk("pwr_len", c, N);
      chk("pwr_done", 32'(done), 1);
      step();
      chk("pwr_done_end", 32'(done), 0);

      foreach (rd[i]) begin
         sr_addr = AW'(rd[i]); zr_addr = AW'(rd[i]);
         step();
         chk("pwr_sr", 32'(sr_pixel), 0);
         chk("pwr_zr", 32'(zr_data), 32'h0FF);
      end

      w_addr = 11'd321; fb_we = 1; pix = 12'hF80; zb_we = 1; zd = 8'h40;
      step();
      fb_we = 0; zb_we = 0;
      sr_addr = 11'd321; zr_addr = 11'd321;
      step();
      chk("w321_sr", 32'(sr_pixel), 32'hF80);
      chk("w321_zr", 32'(zr_data), 32'h40);
      zr_addr = 11'd322;
      step();
      chk("w322_zr", 32'(zr_data), 32'hFF);

      w_addr = 11'd1000; zr_addr = 11'd1000; sr_addr = 11'd1000;
      zb_we = 1; zd = 8'h22; fb_we = 1; pix = 12'h0F0;
      step();
      zb_we = 0; fb_we = 0;
      chk("byp_zr", 32'(zr_data), 32'h22);
      chk("byp_sr_old", 32'(sr_pixel), 0);
      step();
      chk("byp_sr_new", 32'(sr_pixel), 32'h0F0);
      chk("byp_zr_mem", 32'(zr_data), 32'h22);

      w_addr = AW'(N); zb_we = 1; zd = 8'h01;
      step();
      zb_we = 0;
      chk("oob_set", 32'(oob), 1);
      zr_addr = AW'(N); sr_addr = AW'(N);
      step();
      chk("oob_zr", 32'(zr_data), 32'hFF);
      chk("oob_sr", 32'(sr_pixel), 0);
      repeat (3) step();
      chk("oob_sticky", 32'(oob), 1);

      clr = 1;
      step();
      clr = 0;
      chk("clr_busy", 32'(busy), 1);
      chk("clr_oob", 32'(oob), 0);
      c = 0;
      while (busy && c < 4 * N) begin
         clr = (c == 10);
         if (c >= 100 && c < 103) begin
            w_addr = 11'd5; zb_we = 1; zd = 8'h10;
            fb_we = 1; pix = 12'h123;
         end else begin
            zb_we = 0; fb_we = 0;
         end
         step();
         c++;
      end
      clr = 0; zb_we = 0; fb_we = 0;
      chk("clr_len", c, N);
      chk("clr_done", 32'(done), 1);
      sr_addr = 11'd5; zr_addr = 11'd5;
      step();
      chk("drop_sr", 32'(sr_pixel), 0);
      chk("drop_zr", 32'(zr_data), 32'hFF);

      w_addr = 11'd1100; fb_we = 1; pix = 12'hABC; zb_we = 1; zd = 8'h33;
      step();
      fb_we = 0; zb_we = 0;
      clr = 1;
      step();
      clr = 0;
      repeat (999) step();
      rst_n = 1'b0;
      #1;
      chk("abort_busy0", 32'(busy0), 0);
      chk("abort_busy", 32'(busy), 1);
      repeat (2) begin
         step();
         chk("abort_done0", 32'(done0), 0);
      end
      rst_n = 1'b1;
      sr_addr = 11'd1100; zr_addr = 11'd1100;
      step();
      chk("keep_sr", 32'(sr_pixel), 32'hABC);
      chk("keep_sr0", 32'(sr0), 32'hABC);
      chk("keep_zr0", 32'(zr0), 32'h33);
      chk("idle_busy0", 32'(busy0), 0);
      wait_idle(c);
      chk("restart_len", c + 1, N);
      chk("restart_done", 32'(done), 1);
      chk("restart_done0", 32'(done0), 0);
      step();
      chk("swept_sr", 32'(sr_pixel), 0);
      chk("swept_zr", 32'(zr_data), 32'hFF);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
